lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_if.sv | 38 +++
 rtl/lsu_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if -- request/response bus between the core datapath and the
// load/store unit controller.
//
// Signals:
//   req_valid   datapath presents a load/store; req_* held stable while stall=1
//   req_we      1 = store, 0 = load
//   req_size    00 byte, 01 halfword, 10/11 word
//   req_signed  sign-extend sub-word loads
//   req_addr    byte address
//   req_wdata   right-aligned store data
//   stall       freezes PC and register-file writes while high
//   rsp_valid   one-cycle completion pulse
//   rsp_rdata   extended load data (0 for stores), valid with rsp_valid
//   misaligned  misalignment flag, valid with rsp_valid
//
// Modports: master = datapath side, slave = load/store controller side.
interface lsu_ctrl_if;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        misaligned;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  stall, rsp_valid, rsp_rdata, misaligned
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output stall, rsp_valid, rsp_rdata, misaligned
   );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store unit controller in front of a single-port
// synchronous data RAM. Loads read and extend a byte/halfword/word, word
// stores write directly, sub-word stores do read-merge-write.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   bus        lsu_ctrl_if.slave: req_* from the datapath, stall/rsp_* back
//   mem_en     RAM access enable
//   mem_we     RAM write enable
//   mem_addr   RAM word address (req_addr[ADDR_W+1:2])
//   mem_wdata  RAM write data
//   mem_rdata  RAM read data, valid the cycle after a read
//
// Build option: define LSU_MISALIGN_TRAP_EN to flag misaligned halfword/word
// accesses (no memory access, misaligned=1). Without it misaligned is tied
// to 0 and the low address bits are ignored for lane selection.
module lsu_ctrl #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   lsu_ctrl_if.slave         bus,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t      state_r;
   logic [31:0] cap_r;
   logic [31:0] rsp_rdata_r;
   logic        rsp_valid_r;
   logic        misaligned_r;
   logic        rst_hold_r;

   logic        is_word_s;
   logic        misalign_s;
   logic        block_s;
   logic [1:0]  lane_s;
   logic        unused_s;

   // Byte/halfword selection from a RAM word with sign or zero extension.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic        sgn,
                                                input logic [1:0]  lane);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      case (size)
         2'b00:   load_extract = {{24{sgn & b[7]}}, b};
         2'b01:   load_extract = {{16{sgn & h[15]}}, h};
         default: load_extract = word;
      endcase
   endfunction

   // Overlay right-aligned store data onto the captured RAM word.
   function automatic logic [31:0] store_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
      logic [31:0] r;
      r = word;
      case (size)
         2'b00:   r[{lane, 3'b000} +: 8]    = wdata[7:0];
         2'b01:   r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         default: r = wdata;
      endcase
      return r;
   endfunction

   // Request decode: width, lane (low bits forced to alignment) and trap check.
   always_comb begin
      is_word_s = bus.req_size[1];
      block_s   = reset | rst_hold_r;
      case (bus.req_size)
         2'b00:   lane_s = bus.req_addr[1:0];
         2'b01:   lane_s = {bus.req_addr[1], 1'b0};
         default: lane_s = 2'b00;
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_s = ((bus.req_size == 2'b01) & bus.req_addr[0]) |
                   (is_word_s & (bus.req_addr[1:0] != 2'b00));
`else
      misalign_s = 1'b0;
`endif
   end

   // Address bits above the RAM window do not take part in the access.
   assign unused_s = ^bus.req_addr[31:ADDR_W+2];

   // RAM port drive; reset and the cycle after it never touch the RAM.
   always_comb begin
      mem_addr  = bus.req_addr[ADDR_W+1:2];
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = bus.req_wdata;
      if (block_s) begin
         mem_en = 1'b0;
         mem_we = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.req_valid && !misalign_s) begin
                  mem_en = 1'b1;
                  mem_we = bus.req_we & is_word_s;
               end else begin
                  mem_en = 1'b0;
                  mem_we = 1'b0;
               end
            end
            WRITE: begin
               // Dropping req_valid here aborts the write.
               mem_en    = bus.req_valid;
               mem_we    = bus.req_valid;
               mem_wdata = store_merge(cap_r, bus.req_wdata, bus.req_size, lane_s);
            end
            default: begin
               mem_en = 1'b0;
               mem_we = 1'b0;
            end
         endcase
      end
   end

   assign bus.stall      = bus.req_valid & (state_r != DONE) & ~block_s;
   assign bus.rsp_valid  = rsp_valid_r;
   assign bus.rsp_rdata  = rsp_rdata_r;
   assign bus.misaligned = misaligned_r;

   // Controller FSM with registered response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         cap_r        <= 32'd0;
         rsp_rdata_r  <= 32'd0;
         rsp_valid_r  <= 1'b0;
         misaligned_r <= 1'b0;
         rst_hold_r   <= 1'b1;
      end else begin
         rst_hold_r  <= 1'b0;
         rsp_valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.req_valid && !rst_hold_r) begin
                  if (misalign_s) begin
                     state_r      <= DONE;
                     rsp_valid_r  <= 1'b1;
                     rsp_rdata_r  <= 32'd0;
                     misaligned_r <= 1'b1;
                  end else if (bus.req_we && is_word_s) begin
                     state_r      <= DONE;
                     rsp_valid_r  <= 1'b1;
                     rsp_rdata_r  <= 32'd0;
                     misaligned_r <= 1'b0;
                  end else begin
                     state_r <= RD_WAIT;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            RD_WAIT: begin
               if (!bus.req_valid) begin
                  state_r <= IDLE;
               end else begin
                  cap_r <= mem_rdata;
                  if (bus.req_we) begin
                     state_r <= WRITE;
                  end else begin
                     state_r      <= DONE;
                     rsp_valid_r  <= 1'b1;
                     rsp_rdata_r  <= load_extract(mem_rdata, bus.req_size,
                                                  bus.req_signed, lane_s);
                     misaligned_r <= 1'b0;
                  end
               end
            end
            WRITE: begin
               if (!bus.req_valid) begin
                  state_r <= IDLE;
               end else begin
                  state_r      <= DONE;
                  rsp_valid_r  <= 1'b1;
                  rsp_rdata_r  <= 32'd0;
                  misaligned_r <= 1'b0;
               end
            end
            DONE:    state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule
